// File: rtl/amba3_axi_mem_slave_if.sv
// rtl/amba3_axi_mem_slave_if.sv - AXI3 channel bundle between a bus master and the memory slave
interface amba3_axi_mem_slave_if #(
    parameter int TXID_SIZE = 4,
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 128
);
    logic [TXID_SIZE-1:0]   awid;
    logic [ADDR_SIZE-1:0]   awaddr;
    logic [3:0]             awlen;
    logic [2:0]             awsize;
    logic [1:0]             awburst;
    logic                   awvalid;
    logic                   awready;

    logic [TXID_SIZE-1:0]   wid;
    logic [DATA_SIZE-1:0]   wdata;
    logic [DATA_SIZE/8-1:0] wstrb;
    logic                   wlast;
    logic                   wvalid;
    logic                   wready;

    logic [TXID_SIZE-1:0]   bid;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;

    logic [TXID_SIZE-1:0]   arid;
    logic [ADDR_SIZE-1:0]   araddr;
    logic [3:0]             arlen;
    logic [2:0]             arsize;
    logic [1:0]             arburst;
    logic                   arvalid;
    logic                   arready;

    logic [TXID_SIZE-1:0]   rid;
    logic [DATA_SIZE-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rlast;
    logic                   rvalid;
    logic                   rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wid, wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wid, wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );
endinterface

// File: rtl/amba3_axi_mem_slave.sv
// rtl/amba3_axi_mem_slave.sv - AXI3 memory slave with independent write/read FSMs, FIXED/INCR/WRAP bursts
module amba3_axi_mem_slave #(
    parameter int                   TXID_SIZE = 4,
    parameter int                   ADDR_SIZE = 32,
    parameter int                   DATA_SIZE = 128,
    parameter int                   MEM_DEPTH = 1024,
    parameter logic [ADDR_SIZE-1:0] MEM_BASE  = '0
) (
    input  logic                 aclk,
    input  logic                 areset,
    amba3_axi_mem_slave_if.slave axi
);
    localparam int              B   = DATA_SIZE / 8;
    localparam int              BW  = $clog2(B);
    localparam int              IW  = $clog2(MEM_DEPTH);
    localparam logic [63:0]     WIN = 64'(MEM_DEPTH) * 64'(B);
    localparam logic [ADDR_SIZE-1:0] ONE = ADDR_SIZE'(1);
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA} r_state_e;

    function automatic logic [ADDR_SIZE-1:0] beat_addr(input logic [ADDR_SIZE-1:0] addr,
            input logic [2:0] size, input logic [3:0] len, input logic [1:0] burst, input logic [3:0] n);
        logic [ADDR_SIZE-1:0] nbytes, aligned, step, bound;
        nbytes  = ONE << size;
        aligned = addr & ~(nbytes - ONE);
        step    = ADDR_SIZE'(n) << size;
        bound   = nbytes * (ADDR_SIZE'(len) + ONE);
        case (burst)
            2'b01:   beat_addr = (n == 4'd0) ? addr : aligned + step;
            2'b10:   beat_addr = (aligned & ~(bound - ONE)) | ((aligned + step) & (bound - ONE));
            default: beat_addr = addr;
        endcase
    endfunction

    function automatic logic in_win(input logic [ADDR_SIZE-1:0] a);
        logic [ADDR_SIZE-1:0] off;
        off = a - MEM_BASE;
        return 64'(off) < WIN;
    endfunction

    // The whole burst is judged up front so an error burst never touches memory.
    function automatic logic burst_err(input logic [ADDR_SIZE-1:0] addr,
            input logic [2:0] size, input logic [3:0] len, input logic [1:0] burst);
        logic err;
        err = (int'(size) > BW) || (burst == 2'b11) ||
              ((burst == 2'b10) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
        for (int n = 0; n < 16; n++) begin
            if ((4'(n) <= len) && !in_win(beat_addr(addr, size, len, burst, 4'(n)))) err = 1'b1;
        end
        return err;
    endfunction

    function automatic logic [B-1:0] lane_mask(input logic [ADDR_SIZE-1:0] a, input logic [2:0] size);
        int lo;
        lo = int'(a[BW-1:0]);
        for (int k = 0; k < B; k++) lane_mask[k] = (k >= lo) && ((k >> size) == (lo >> size));
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [ADDR_SIZE-1:0] a);
        return IW'((a - MEM_BASE) >> BW);
    endfunction

    logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

    // ---------------- write channel ----------------
    w_state_e               w_state_q, w_state_d;
    logic                   live_q;
    logic [ADDR_SIZE-1:0]   aw_addr_q;
    logic [2:0]             aw_size_q;
    logic [3:0]             aw_len_q;
    logic [1:0]             aw_burst_q;
    logic [TXID_SIZE-1:0]   bid_q;
    logic [1:0]             bresp_q;
    logic                   w_err_q, w_proto_q;
    logic [3:0]             w_beat_q;
    logic                   awready, wready, bvalid, aw_hs, w_hs, w_last_beat, wlast_bad, aw_err;
    logic [ADDR_SIZE-1:0]   w_addr;
    logic [B-1:0]           w_be;
    logic                   unused_wid;

    assign unused_wid  = ^axi.wid;
    assign aw_hs       = axi.awvalid && awready;
    assign w_hs        = axi.wvalid && wready;
    assign w_last_beat = (w_beat_q == aw_len_q);
    assign wlast_bad   = (axi.wlast != w_last_beat);
    assign aw_err      = burst_err(axi.awaddr, axi.awsize, axi.awlen, axi.awburst);
    assign w_addr      = beat_addr(aw_addr_q, aw_size_q, aw_len_q, aw_burst_q, w_beat_q);
    assign w_be        = axi.wstrb & lane_mask(w_addr, aw_size_q);

    always_comb begin
        w_state_d = w_state_q;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                awready = live_q;
                if (axi.awvalid && live_q) w_state_d = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (axi.wvalid && w_last_beat) w_state_d = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (axi.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state_q  <= W_IDLE;
            live_q     <= 1'b0;
            aw_addr_q  <= '0;
            aw_size_q  <= '0;
            aw_len_q   <= '0;
            aw_burst_q <= '0;
            bid_q      <= '0;
            bresp_q    <= RESP_OKAY;
            w_err_q    <= 1'b0;
            w_proto_q  <= 1'b0;
            w_beat_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            live_q    <= 1'b1;
            if (aw_hs) begin
                aw_addr_q  <= axi.awaddr;
                aw_size_q  <= axi.awsize;
                aw_len_q   <= axi.awlen;
                aw_burst_q <= axi.awburst;
                bid_q      <= axi.awid;
                w_err_q    <= aw_err;
                w_proto_q  <= 1'b0;
                w_beat_q   <= '0;
            end
            if (w_hs) begin
                w_beat_q  <= w_beat_q + 4'd1;
                w_proto_q <= w_proto_q || wlast_bad;
                if (w_last_beat)
                    bresp_q <= (w_err_q || w_proto_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && !w_err_q) begin
            for (int k = 0; k < B; k++)
                if (w_be[k]) mem[word_idx(w_addr)][8*k +: 8] <= axi.wdata[8*k +: 8];
        end
    end

    assign axi.awready = awready;
    assign axi.wready  = wready;
    assign axi.bvalid  = bvalid;
    assign axi.bid     = bid_q;
    assign axi.bresp   = bresp_q;

    // ---------------- read channel ----------------
    r_state_e               r_state_q, r_state_d;
    logic [ADDR_SIZE-1:0]   ar_addr_q;
    logic [2:0]             ar_size_q;
    logic [3:0]             ar_len_q;
    logic [1:0]             ar_burst_q;
    logic [TXID_SIZE-1:0]   rid_q;
    logic                   r_err_q, rlast_q;
    logic [3:0]             r_beat_q;
    logic [DATA_SIZE-1:0]   rdata_q, r_data_d, r_word;
    logic [1:0]             rresp_q;
    logic                   arready, rvalid, ar_hs, r_hs, r_last_beat, r_load_err;
    logic [ADDR_SIZE-1:0]   r_load_addr;
    logic [2:0]             r_load_size;
    logic [B-1:0]           r_mask;

    assign ar_hs       = axi.arvalid && arready;
    assign r_hs        = rvalid && axi.rready;
    assign r_last_beat = (r_beat_q == ar_len_q);

    // Beat 0 is fetched straight from the AR inputs; later beats from the latched command.
    always_comb begin
        if (r_state_q == R_IDLE) begin
            r_load_addr = beat_addr(axi.araddr, axi.arsize, axi.arlen, axi.arburst, 4'd0);
            r_load_size = axi.arsize;
            r_load_err  = burst_err(axi.araddr, axi.arsize, axi.arlen, axi.arburst);
        end else begin
            r_load_addr = beat_addr(ar_addr_q, ar_size_q, ar_len_q, ar_burst_q, r_beat_q + 4'd1);
            r_load_size = ar_size_q;
            r_load_err  = r_err_q;
        end
    end

    assign r_mask = lane_mask(r_load_addr, r_load_size);
    assign r_word = mem[word_idx(r_load_addr)];

    always_comb begin
        r_data_d = '0;
        for (int k = 0; k < B; k++)
            if (r_mask[k] && !r_load_err) r_data_d[8*k +: 8] = r_word[8*k +: 8];
    end

    always_comb begin
        r_state_d = r_state_q;
        arready   = 1'b0;
        rvalid    = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                arready = live_q;
                if (axi.arvalid && live_q) r_state_d = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (axi.rready && r_last_beat) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state_q  <= R_IDLE;
            ar_addr_q  <= '0;
            ar_size_q  <= '0;
            ar_len_q   <= '0;
            ar_burst_q <= '0;
            rid_q      <= '0;
            r_err_q    <= 1'b0;
            r_beat_q   <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                ar_addr_q  <= axi.araddr;
                ar_size_q  <= axi.arsize;
                ar_len_q   <= axi.arlen;
                ar_burst_q <= axi.arburst;
                rid_q      <= axi.arid;
                r_err_q    <= r_load_err;
                r_beat_q   <= '0;
                rdata_q    <= r_data_d;
                rresp_q    <= r_load_err ? RESP_SLVERR : RESP_OKAY;
                rlast_q    <= (axi.arlen == 4'd0);
            end else if (r_hs && !r_last_beat) begin
                r_beat_q <= r_beat_q + 4'd1;
                rdata_q  <= r_data_d;
                rlast_q  <= ((r_beat_q + 4'd1) == ar_len_q);
            end
        end
    end

    assign axi.arready = arready;
    assign axi.rvalid  = rvalid;
    assign axi.rid     = rid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.rlast   = rlast_q;
endmodule

// File: tb/tb_amba3_axi_mem_slave.sv
// tb/tb_amba3_axi_mem_slave.sv - randomized bench for amba3_axi_mem_slave against a byte-array memory model
`timescale 1ns/1ps
module tb_amba3_axi_mem_slave;
    localparam int TXID = 4, AW = 32, DW = 128, DEPTH = 1024, NB = 16;
    localparam int unsigned WIN = DEPTH * NB;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    amba3_axi_mem_slave_if #(.TXID_SIZE(TXID), .ADDR_SIZE(AW), .DATA_SIZE(DW)) axi ();

    amba3_axi_mem_slave #(
        .TXID_SIZE(TXID), .ADDR_SIZE(AW), .DATA_SIZE(DW), .MEM_DEPTH(DEPTH), .MEM_BASE(32'h0)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .axi    (axi)
    );

    int           n_cmp = 0;
    int           n_bad = 0;
    byte unsigned ref_mem [WIN];
    logic [127:0] wd [16];
    logic [15:0]  ws [16];
    logic [127:0] rd_got [16];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned m_beat(int unsigned a, int sz, int ln, int bt, int n);
        int unsigned nb, al, bound, lower;
        nb = 32'd1 << sz;
        al = a / nb * nb;
        if (bt == 1) return (n == 0) ? a : al + int'(n) * nb;
        if (bt == 2) begin
            bound = nb * int'(ln + 1);
            lower = al / bound * bound;
            return lower + (al - lower + int'(n) * nb) % bound;
        end
        return a;
    endfunction

    function automatic bit m_err(int unsigned a, int sz, int ln, int bt);
        if (sz > 4 || bt == 3) return 1'b1;
        if (bt == 2 && !(ln == 1 || ln == 3 || ln == 7 || ln == 15)) return 1'b1;
        for (int n = 0; n <= ln; n++)
            if (m_beat(a, sz, ln, bt, n) >= WIN) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_lane_on(int unsigned ba, int sz, int k);
        int unsigned lo, nb;
        lo = ba % NB;
        nb = 32'd1 << sz;
        return (k >= int'(lo)) && (k <= int'(lo / nb * nb + nb - 1));
    endfunction

    function automatic logic [127:0] m_rdata(int unsigned ba, int sz, bit err);
        logic [127:0] d;
        d = '0;
        if (!err)
            for (int k = 0; k < NB; k++)
                if (m_lane_on(ba, sz, k)) d[8*k +: 8] = ref_mem[ba / NB * NB + k];
        return d;
    endfunction

    task automatic axi_write(input int unsigned a, input int ln, input int sz, input int bt,
                             input int early, input int abort_after, input bit stall, input logic [3:0] id);
        int t, n;
        bit err, perr, lst, done;
        int unsigned ba;
        logic [1:0] exp_resp;
        err  = m_err(a, sz, ln, bt);
        perr = 1'b0;
        @(negedge aclk);
        axi.awvalid = 1'b1; axi.awaddr = a; axi.awlen = 4'(ln);
        axi.awsize = 3'(sz); axi.awburst = 2'(bt); axi.awid = id;
        t = 0;
        while (!axi.awready && t < 50) begin @(negedge aclk); t++; end
        check("aw_accept", axi.awready, 1'b1);
        @(negedge aclk);
        axi.awvalid = 1'b0;
        for (n = 0; n <= ln; n++) begin
            if (stall) repeat ($urandom_range(0, 2)) begin axi.wvalid = 1'b0; @(negedge aclk); end
            lst = (early >= 0) ? (n == early) : (n == ln);
            if (lst != (n == ln)) perr = 1'b1;
            axi.wvalid = 1'b1; axi.wdata = wd[n]; axi.wstrb = ws[n]; axi.wlast = lst; axi.wid = id;
            t = 0;
            while (!axi.wready && t < 50) begin @(negedge aclk); t++; end
            check("w_accept", axi.wready, 1'b1);
            if (!err) begin
                ba = m_beat(a, sz, ln, bt, n);
                for (int k = 0; k < NB; k++)
                    if (ws[n][k] && m_lane_on(ba, sz, k)) ref_mem[ba / NB * NB + k] = wd[n][8*k +: 8];
            end
            @(negedge aclk);
            if (abort_after >= 0 && n + 1 == abort_after) begin
                axi.wvalid = 1'b0;
                return;
            end
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        check("bvalid_rise", axi.bvalid, 1'b1);
        exp_resp = (err || perr) ? 2'b10 : 2'b00;
        done = 1'b0; t = 0;
        while (!done && t < 60) begin
            axi.bready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!axi.bvalid) begin
                check("bvalid_hold", axi.bvalid, 1'b1);
                done = 1'b1;
            end else begin
                check("bid", axi.bid, id);
                check("bresp", axi.bresp, exp_resp);
                if (axi.bready) done = 1'b1;
            end
            @(negedge aclk); t++;
        end
        axi.bready = 1'b0;
        check("b_done", done, 1'b1);
        check("bvalid_drop", axi.bvalid, 1'b0);
    endtask

    task automatic axi_read(input int unsigned a, input int ln, input int sz, input int bt,
                            input bit stall, input logic [3:0] id);
        int t, n;
        bit err;
        err = m_err(a, sz, ln, bt);
        @(negedge aclk);
        axi.arvalid = 1'b1; axi.araddr = a; axi.arlen = 4'(ln);
        axi.arsize = 3'(sz); axi.arburst = 2'(bt); axi.arid = id;
        t = 0;
        while (!axi.arready && t < 50) begin @(negedge aclk); t++; end
        check("ar_accept", axi.arready, 1'b1);
        @(negedge aclk);
        axi.arvalid = 1'b0;
        n = 0; t = 0;
        while (n <= ln && t < 200) begin
            axi.rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            check("rvalid", axi.rvalid, 1'b1);
            if (!axi.rvalid) break;
            check("rdata", axi.rdata, m_rdata(m_beat(a, sz, ln, bt, n), sz, err));
            check("rresp", axi.rresp, err ? 2'b10 : 2'b00);
            check("rlast", axi.rlast, n == ln);
            check("rid", axi.rid, id);
            if (axi.rready) begin rd_got[n] = axi.rdata; n++; end
            @(negedge aclk); t++;
        end
        axi.rready = 1'b0;
        check("r_done", n, ln + 1);
        check("rvalid_drop", axi.rvalid, 1'b0);
    endtask

    task automatic fill_random;
        for (int i = 0; i < 16; i++) begin
            wd[i] = {$urandom, $urandom, $urandom, $urandom};
            ws[i] = 16'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned a, a2;
        int ln, sz, bt, ln2, sz2;
        axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0;
        axi.wvalid = 0; axi.wid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 0;
        axi.arvalid = 0; axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0;
        axi.rready = 0;

        repeat (5) @(posedge aclk);
        @(negedge aclk);
        check("rst_awready", axi.awready, 1'b0);
        check("rst_arready", axi.arready, 1'b0);
        check("rst_wready", axi.wready, 1'b0);
        check("rst_bvalid", axi.bvalid, 1'b0);
        check("rst_rvalid", axi.rvalid, 1'b0);
        check("rst_rlast", axi.rlast, 1'b0);
        check("rst_rdata", axi.rdata, 128'h0);
        check("rst_bresp", axi.bresp, 2'b00);
        areset = 1'b0;
        #1;
        check("awready_before_edge", axi.awready, 1'b0);
        @(negedge aclk);
        check("awready_after_rst", axi.awready, 1'b1);
        check("arready_after_rst", axi.arready, 1'b1);

        for (int i = 0; i < DEPTH / 16; i++) begin
            fill_random();
            for (int j = 0; j < 16; j++) ws[j] = 16'hFFFF;
            axi_write(i * 256, 15, 4, 1, -1, -1, 1'b0, 4'(i));
        end

        wd[0] = 128'h4739 << 32; wd[1] = 128'h7163 << 64; wd[2] = 128'hA395 << 96; wd[3] = 128'h1507;
        for (int j = 0; j < 4; j++) ws[j] = 16'hFFFF;
        axi_write(32'h104, 3, 2, 1, -1, -1, 1'b0, 4'h3);
        axi_read(32'h104, 3, 2, 1, 1'b0, 4'h5);
        check("narrow_b0", rd_got[0], 128'h4739 << 32);
        check("narrow_b1", rd_got[1], 128'h7163 << 64);
        check("narrow_b2", rd_got[2], 128'hA395 << 96);
        check("narrow_b3", rd_got[3], 128'h1507);

        fill_random();
        axi_write(32'h201, 2, 3, 1, -1, -1, 1'b0, 4'h1);
        axi_read(32'h200, 1, 4, 1, 1'b0, 4'h2);
        axi_read(32'h201, 2, 3, 1, 1'b0, 4'h2);

        fill_random();
        axi_write(32'h704, 3, 2, 2, -1, -1, 1'b0, 4'h6);
        axi_read(32'h704, 3, 2, 2, 1'b0, 4'h7);
        fill_random();
        axi_write(32'h704, 2, 2, 2, -1, -1, 1'b0, 4'h8);
        axi_read(32'h700, 0, 4, 1, 1'b0, 4'h9);

        axi_read(WIN, 3, 4, 1, 1'b0, 4'hA);
        axi_read(WIN - 16, 1, 4, 1, 1'b0, 4'hB);

        fill_random();
        axi_write(32'h800, 3, 2, 1, 1, -1, 1'b0, 4'hC);
        axi_read(32'h800, 3, 2, 1, 1'b0, 4'hD);

        for (int i = 0; i < 40; i++) begin
            fill_random();
            a  = ($urandom_range(0, 7) == 0) ? $urandom_range(WIN - 128, WIN + 64) : $urandom_range(0, WIN - 1);
            ln = $urandom_range(0, 15);
            sz = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 4);
            bt = $urandom_range(0, 3);
            axi_write(a, ln, sz, bt, -1, -1, 1'b1, 4'($urandom));
            axi_read(a, ln, sz, bt, 1'b1, 4'($urandom));
        end

        for (int i = 0; i < 8; i++) begin
            fill_random();
            a   = $urandom_range(32'h2000, 32'h27FF);
            a2  = $urandom_range(32'h3000, 32'h37FF);
            ln  = $urandom_range(0, 15); sz  = $urandom_range(0, 4);
            ln2 = $urandom_range(0, 15); sz2 = $urandom_range(0, 4);
            fork
                axi_write(a, ln, sz, 1, -1, -1, 1'b1, 4'(i));
                axi_read(a2, ln2, sz2, 1, 1'b1, 4'(i + 8));
            join
        end

        fill_random();
        axi_write(32'h3800, 7, 4, 1, -1, 3, 1'b0, 4'hE);
        areset = 1'b1;
        #1;
        check("midrst_awready", axi.awready, 1'b0);
        check("midrst_wready", axi.wready, 1'b0);
        check("midrst_bvalid", axi.bvalid, 1'b0);
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check("postrst_awready", axi.awready, 1'b1);
        check("postrst_wready", axi.wready, 1'b0);
        check("postrst_bvalid", axi.bvalid, 1'b0);
        axi_read(32'h3800, 7, 4, 1, 1'b0, 4'h4);
        fill_random();
        axi_write(32'h3810, 1, 4, 1, -1, -1, 1'b0, 4'h2);
        axi_read(32'h3800, 3, 4, 1, 1'b1, 4'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/amba3_axi_mem_slave.md
# amba3_axi_mem_slave

Synthesizable AMBA3 AXI slave memory with independent write and read channels, parametrised in ID, address, data width and memory depth. It supports FIXED, INCR and WRAP bursts, narrow and unaligned transfers, and byte strobes. It returns SLVERR for out-of-window or illegal bursts. It attaches to an `amba3_axi_if` bus as an RTL target, so bus-level master traffic can run against real hardware instead of the behavioural slave class.

## Interface
- TXID_SIZE, 4, ID width
- ADDR_SIZE, 32, address width
- DATA_SIZE, 128, data width in bits; power of 2, 32..1024
- MEM_DEPTH, 1024, memory depth in DATA_SIZE words; power of 2
- MEM_BASE, 0, byte base address of the window; aligned to MEM_DEPTH*DATA_SIZE/8
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- awid/awaddr/awlen/awsize/awburst  in  TXID_SIZE/ADDR_SIZE/4/3/2  write address
- awvalid in 1; awready out 1
- wid/wdata/wstrb/wlast  in  TXID_SIZE/DATA_SIZE/DATA_SIZE/8/1  write data
- wvalid in 1; wready out 1
- bid/bresp  out  TXID_SIZE/2  write response
- bvalid out 1; bready in 1
- arid/araddr/arlen/arsize/arburst  in  same widths as AW  read address
- arvalid in 1; arready out 1
- rid/rdata/rresp/rlast  out  TXID_SIZE/DATA_SIZE/2/1  read data
- rvalid out 1; rready in 1

## Operation
- Derived values:
  - B = DATA_SIZE/8
  - nbytes = 1<<size
  - aligned = addr & ~(nbytes-1)
  - word index = (addr-MEM_BASE)>>log2(B)
- Beat address n:
  - FIXED: addr for every beat.
  - INCR: beat 0 = addr; beat n = aligned + n*nbytes.
  - WRAP: bound = nbytes*(len+1); beat n = (aligned & ~(bound-1)) | ((aligned + n*nbytes) & (bound-1)). Start address is treated as aligned.
- Active lanes per beat: bytes from (beat_addr mod B) up to the end of its nbytes container within the word.
- Write effect: byte k is written iff wstrb[k] and k is an active lane.
- Read data: active lanes carry memory bytes; all other lanes are 0.
- Error conditions (any one makes the burst an error burst):
  - nbytes > B
  - WRAP with len not in {1,3,7,15}
  - any beat address outside [MEM_BASE, MEM_BASE + MEM_DEPTH*B)
  - burst type 2'b11
- Error burst behaviour:
  - All beats are still handshaken.
  - No memory byte is written.
  - Write: bresp = SLVERR (2'b10).
  - Read: every beat has rresp = SLVERR and rdata = 0.
  - Otherwise the response is OKAY.
- Write FSM:
  - W_IDLE: awready=1. AW handshake latches the command and moves to W_DATA.
  - W_DATA: wready=1. Each W handshake commits one beat. After beat len+1, move to W_RESP.
  - W_RESP: bvalid=1, bid=awid. B handshake returns to W_IDLE.
- Write beat count comes from awlen only. wlast missing on the final beat, or asserted early, forces bresp=SLVERR; the memory writes still occur. wid is ignored.
- Read FSM:
  - R_IDLE: arready=1. AR handshake latches the command, loads beat 0 into the rdata register and moves to R_DATA.
  - R_DATA: rvalid=1, rid=arid, rlast=1 on beat len. An R handshake loads the next beat. The handshake on the last beat returns to R_IDLE.
- Read and write FSMs are fully independent; both may be active at once.
- Same-edge collision: a read beat loaded on the same edge as a write to the same word returns pre-write contents.
- Memory is not cleared by reset.

## Timing
- areset asserted, immediately and for its duration:
  - awready, wready, bvalid, arready, rvalid, rlast = 0
  - bid, bresp, rid, rresp, rdata = 0
  - both FSMs forced to IDLE; any in-flight burst is dropped with no response
- awready and arready rise on the first rising edge after areset deasserts.
- awready/arready are decoded from state only and are not dependent on awvalid/arvalid.
- Write: AW accepted at edge 0; the earliest W beat is accepted at edge 1; bvalid rises the cycle after the last W handshake.
- Read: AR accepted at edge 0; rvalid with beat 0 is visible after edge 0. With rready held high, one beat per cycle.
- rdata/rresp/rlast/rid are held stable while rvalid && !rready. bid/bresp are held stable while bvalid && !bready.
- Back-to-back: the next AW (AR) can be accepted the cycle after the B (last R) handshake.
- Address arithmetic uses ADDR_SIZE bits and wraps modulo 2^ADDR_SIZE. Beats crossing the window top are errors, not wrapped.

## Test plan
- Reset: hold areset for 5 cycles -> all valids/readies 0; awready=arready=1 one cycle after release.
- INCR narrow: write at 0x104, size 4 B, len 3, data 0x4739/0x7163/0xA395/0x1507 -> beat strobes land on lanes 4-7, 8-11, 12-15 of word 0x100 and lanes 0-3 of word 0x110. Read back the same burst -> rdata beats are 0x4739<<32, 0x7163<<64, 0xA395<<96, 0x1507; bresp=rresp=OKAY.
- Unaligned INCR: size 8 B at 0x201, len 2 -> active lanes 1-7, 8-15 and 0-7 (word 0x210).
- WRAP: size 4 B at 0x704, len 3 -> beat addresses 0x704, 0x708, 0x70C, 0x700. WRAP with len 2 -> SLVERR, memory unchanged.
- Errors and protocol: read at MEM_BASE + MEM_DEPTH*16 -> all beats SLVERR, rdata 0. A write with wlast on beat 1 of len 3 -> 4 beats accepted, bresp SLVERR.
- Concurrency and reset: overlapping read and write bursts with random rready/bready stalls -> every response is stable while stalled. areset pulsed mid-write -> no bvalid, FSM returns to idle.
